// File: rtl/trade_pkg.sv
// Shared types and sizing helpers for the trade signal engine.
package trade_pkg;

  typedef enum logic [2:0] {
    FLAT      = 3'd0,
    ARM_BUY   = 3'd1,
    ARM_SELL  = 3'd2,
    HOLD_BUY  = 3'd3,
    HOLD_SELL = 3'd4
  } trade_state_e;

  localparam int TRADE_CNT_W = 16;

  // Width of the confirmation counter, which must be able to hold CONFIRM.
  function automatic int confirm_cnt_w(input int confirm);
    return $clog2(confirm + 1);
  endfunction

endpackage

// File: rtl/trade_cmp.sv
// Combinational price/threshold comparator with hysteresis band, no wrap-around.
module trade_cmp #(
  parameter int PRICE_W = 8,
  parameter int HYST_W  = 4
) (
  input  logic [PRICE_W-1:0] price,
  input  logic [PRICE_W-1:0] threshold,
  input  logic [HYST_W-1:0]  hyst,
  output logic               buy_cond,
  output logic               sell_cond,
  output logic               exit_buy,
  output logic               exit_sell
);

  // One extra bit keeps price+hyst and threshold+hyst from wrapping.
  logic [PRICE_W:0] price_ext;
  logic [PRICE_W:0] thr_ext;
  logic [PRICE_W:0] hyst_ext;

  assign price_ext = {1'b0, price};
  assign thr_ext   = {1'b0, threshold};
  assign hyst_ext  = (PRICE_W + 1)'(hyst);

  assign buy_cond  = (price_ext + hyst_ext) < thr_ext;
  assign sell_cond = price_ext > (thr_ext + hyst_ext);
  assign exit_buy  = price >= threshold;
  assign exit_sell = price <= threshold;

endmodule

// File: rtl/trade_signal_engine.sv
// Confirmed BUY/SELL position FSM with hysteresis hold, trade pulse and counter.
// Optional post-exit cooldown lockout enabled by defining TRADE_COOLDOWN_EN.
module trade_signal_engine
  import trade_pkg::*;
#(
  parameter int PRICE_W      = 8,
  parameter int HYST_W       = 4,
  parameter int CONFIRM      = 4,
  parameter int COOLDOWN_CYC = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_valid,
  input  logic [PRICE_W-1:0]     price_in,
  input  logic [PRICE_W-1:0]     threshold,
  input  logic [HYST_W-1:0]      hyst,
  output logic                   buy_led,
  output logic                   sell_led,
  output logic [2:0]             state_o,
  output logic                   trade_pulse,
  output logic [TRADE_CNT_W-1:0] trade_count
);

  localparam int CNT_W = confirm_cnt_w(CONFIRM);

  if (CONFIRM < 1 || CONFIRM > 255) begin : g_bad_confirm
    $error("trade_signal_engine: CONFIRM must be within 1..255");
  end
  if (COOLDOWN_CYC < 0) begin : g_bad_cooldown
    $error("trade_signal_engine: COOLDOWN_CYC must be non-negative");
  end

  trade_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             buy_cond, sell_cond, exit_buy, exit_sell;
  logic             enter_hold;
  logic             cool_busy;
  logic             leave_hold;

  trade_cmp #(
    .PRICE_W (PRICE_W),
    .HYST_W  (HYST_W)
  ) u_cmp (
    .price     (price_in),
    .threshold (threshold),
    .hyst      (hyst),
    .buy_cond  (buy_cond),
    .sell_cond (sell_cond),
    .exit_buy  (exit_buy),
    .exit_sell (exit_sell)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sample_valid) begin
      unique case (state_q)
        FLAT: begin
          if (buy_cond) begin
            state_d = (CONFIRM == 1) ? HOLD_BUY : ARM_BUY;
            cnt_d   = (CONFIRM == 1) ? '0 : CNT_W'(1);
          end else if (sell_cond) begin
            state_d = (CONFIRM == 1) ? HOLD_SELL : ARM_SELL;
            cnt_d   = (CONFIRM == 1) ? '0 : CNT_W'(1);
          end
        end
        ARM_BUY, ARM_SELL: begin
          if ((state_q == ARM_BUY) ? buy_cond : sell_cond) begin
            if (int'(cnt_q) + 1 == CONFIRM) begin
              state_d = (state_q == ARM_BUY) ? HOLD_BUY : HOLD_SELL;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if ((state_q == ARM_BUY) ? sell_cond : buy_cond) begin
            state_d = (state_q == ARM_BUY) ? ARM_SELL : ARM_BUY;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = FLAT;
            cnt_d   = '0;
          end
        end
        HOLD_BUY: begin
          if (exit_buy) begin
            state_d = !sell_cond ? FLAT : (CONFIRM == 1) ? HOLD_SELL : ARM_SELL;
            cnt_d   = (sell_cond && CONFIRM != 1) ? CNT_W'(1) : '0;
          end
        end
        HOLD_SELL: begin
          if (exit_sell) begin
            state_d = !buy_cond ? FLAT : (CONFIRM == 1) ? HOLD_BUY : ARM_BUY;
            cnt_d   = (buy_cond && CONFIRM != 1) ? CNT_W'(1) : '0;
          end
        end
        default: begin
          state_d = FLAT;
          cnt_d   = '0;
        end
      endcase
    end
    // Any exit from a position, including a direct reversal, lands in FLAT while cooling down.
    if (cool_busy || leave_hold) begin
      state_d = FLAT;
      cnt_d   = '0;
    end
  end

`ifdef TRADE_COOLDOWN_EN
  localparam int COOL_W = (COOLDOWN_CYC < 1) ? 1 : $clog2(COOLDOWN_CYC + 1);

  logic [COOL_W-1:0] cool_q;
  trade_state_e      raw_next;

  // Where the FSM would go with no lockout; used only to detect a position exit.
  always_comb begin
    raw_next = state_q;
    if (sample_valid && ((state_q == HOLD_BUY && exit_buy) ||
                         (state_q == HOLD_SELL && exit_sell))) begin
      raw_next = FLAT;
    end
  end

  assign cool_busy  = (cool_q != '0);
  assign leave_hold = (raw_next != state_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      cool_q <= '0;
    end else if (leave_hold) begin
      cool_q <= COOL_W'(COOLDOWN_CYC);
    end else if (cool_busy) begin
      cool_q <= cool_q - COOL_W'(1);
    end
  end
`else
  assign cool_busy  = 1'b0;
  assign leave_hold = 1'b0;
`endif

  assign enter_hold = ((state_d == HOLD_BUY) && (state_q != HOLD_BUY)) ||
                      ((state_d == HOLD_SELL) && (state_q != HOLD_SELL));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FLAT;
      cnt_q       <= '0;
      buy_led     <= 1'b0;
      sell_led    <= 1'b0;
      trade_pulse <= 1'b0;
      trade_count <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buy_led     <= (state_d == HOLD_BUY);
      sell_led    <= (state_d == HOLD_SELL);
      trade_pulse <= enter_hold;
      if (enter_hold && trade_count != '1) begin
        trade_count <= trade_count + TRADE_CNT_W'(1);
      end
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_trade_signal_engine.sv
// Directed self-checking bench for trade_signal_engine (CONFIRM=4, thr=100, hyst=5 baseline).
module tb_trade_signal_engine;

`ifdef TRADE_COOLDOWN_EN
  localparam bit COOL = 1'b1;
`else
  localparam bit COOL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_valid = 1'b0;
  logic [7:0]  price_in = '0;
  logic [7:0]  threshold = '0;
  logic [3:0]  hyst = '0;
  logic        buy_led, sell_led, trade_pulse;
  logic [2:0]  state_o;
  logic [15:0] trade_count;

  int checks = 0;
  int errors = 0;

  trade_signal_engine #(
    .PRICE_W      (8),
    .HYST_W       (4),
    .CONFIRM      (4),
    .COOLDOWN_CYC (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .price_in     (price_in),
    .threshold    (threshold),
    .hyst         (hyst),
    .buy_led      (buy_led),
    .sell_led     (sell_led),
    .state_o      (state_o),
    .trade_pulse  (trade_pulse),
    .trade_count  (trade_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One valid sample; returns 1 time unit after the edge that consumed it.
  task automatic send(input int p, input int t, input int h);
    @(negedge clk);
    sample_valid = 1'b1;
    price_in     = 8'(p);
    threshold    = 8'(t);
    hyst         = 4'(h);
    @(posedge clk);
    #1 sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("reset_state", state_o, 0);
    check("reset_leds", {buy_led, sell_led}, 0);
    check("reset_pulse", trade_pulse, 0);
    check("reset_count", trade_count, 0);

    // Buy entry with idle gaps between samples.
    for (int i = 1; i <= 3; i++) begin
      send(90, 100, 5);
      idle(2);
      check("arm_buy_gap", state_o, 1);
      check("arm_no_pulse", trade_pulse, 0);
    end
    send(90, 100, 5);
    check("hold_buy_state", state_o, 3);
    check("hold_buy_led", {buy_led, sell_led}, 2'b10);
    check("entry_pulse", trade_pulse, 1);
    check("entry_count", trade_count, 1);
    idle(1);
    check("pulse_one_cycle", trade_pulse, 0);
    check("hold_after_idle", state_o, 3);

    // Hysteresis hold and release.
    send(98, 100, 5);
    check("hold_in_band", state_o, 3);
    send(100, 100, 5);
    check("exit_to_flat", state_o, 0);
    check("exit_led_off", buy_led, 0);
    idle(10);
    send(97, 100, 5);
    check("band_stays_flat", state_o, 0);

    // Reversal from HOLD_BUY into a sell position.
    repeat (4) send(90, 100, 5);
    check("rehold_buy", state_o, 3);
    check("rehold_count", trade_count, 2);
    send(110, 100, 5);
    check("reversal_arm", state_o, COOL ? 0 : 2);
    if (COOL) begin
      idle(10);
      send(110, 100, 5);
    end
    send(110, 100, 5);
    send(110, 100, 5);
    check("arm_sell_cnt3", state_o, 2);
    send(110, 100, 5);
    check("hold_sell_state", state_o, 4);
    check("hold_sell_led", {buy_led, sell_led}, 2'b01);
    check("sell_count", trade_count, 3);
    check("sell_pulse", trade_pulse, 1);

    send(102, 100, 5);
    check("sell_hold_band", state_o, 4);
    send(100, 100, 5);
    check("sell_exit_flat", state_o, 0);
    check("sell_exit_led", sell_led, 0);
    idle(10);

    // Broken streak and arithmetic edges.
    repeat (3) send(90, 100, 5);
    check("streak_cnt3", state_o, 1);
    send(100, 100, 5);
    check("streak_broken", state_o, 0);
    send(0, 0, 5);
    check("thr_zero_no_buy", state_o, 0);
    send(255, 255, 1);
    check("thr_max_no_sell", state_o, 0);
    send(255, 254, 0);
    check("sell_at_top", state_o, 2);
    send(0, 255, 1);
    check("arm_flip_to_buy", state_o, 1);
    send(0, 255, 1);
    send(0, 255, 1);
    check("flip_cnt_restart", state_o, 1);
    send(0, 255, 1);
    check("flip_hold_buy", state_o, 3);
    check("flip_count", trade_count, 4);

    // Synchronous reset while in HOLD_BUY.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_hold_state", state_o, 0);
    check("rst_hold_led", buy_led, 0);
    check("rst_hold_count", trade_count, 0);

`ifdef TRADE_COOLDOWN_EN
    repeat (4) send(90, 100, 5);
    check("cool_hold", state_o, 3);
    send(100, 100, 5);
    check("cool_exit", state_o, 0);
    @(negedge clk);
    sample_valid = 1'b1;
    price_in     = 8'd90;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 check("cool_locked", state_o, 0);
    end
    @(posedge clk);
    #1 check("cool_expired_arm", state_o, 1);
    sample_valid = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
